// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder slice.
// The address-error rule lives here so the top and any future users agree on it.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH   = 64;
    localparam int DEFAULT_LATENCY = 2;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-indexed storage: synchronous write, combinational read.
// Contents are deliberately not reset so committed stores survive a reset.
module mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Store port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: one load/store at a time, answered LATENCY cycles
// after acceptance. Stores commit at acceptance; loads sample the array entering RESP.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int DEPTH   = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        we_r;
    logic        err_r;
    logic [AW-1:0] idx_r;

    logic        req_ready_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;
    logic        req_ready_nxt_s;
    logic        rsp_valid_nxt_s;
    logic        rsp_err_nxt_s;
    logic [31:0] rsp_rdata_nxt_s;

    logic          accept_s;
    logic          req_err_s;
    logic          arr_we_s;
    logic [AW-1:0] req_idx_s;
    logic [AW-1:0] rd_idx_s;
    logic          rd_load_s;
    logic          rd_err_s;
    logic [31:0]   arr_rdata_s;

    assign accept_s  = req_valid && req_ready_r;
    assign req_err_s = addr_err(req_addr, DEPTH);
    assign req_idx_s = req_addr[AW+1:2];
    assign arr_we_s  = accept_s && req_we && !req_err_s;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk   (clk),
        .we    (arr_we_s),
        .waddr (req_idx_s),
        .wdata (req_wdata),
        .raddr (rd_idx_s),
        .rdata (arr_rdata_s)
    );

    // Read source: the live request in IDLE (LATENCY=1 enters RESP from IDLE), else the latched one.
    always_comb begin
        rd_idx_s  = idx_r;
        rd_load_s = 1'b0;
        rd_err_s  = 1'b0;
        if (state_r == IDLE) begin
            rd_idx_s  = req_idx_s;
            rd_load_s = !req_we && !req_err_s;
            rd_err_s  = req_err_s;
        end else begin
            rd_idx_s  = idx_r;
            rd_load_s = !we_r && !err_r;
            rd_err_s  = err_r;
        end
    end

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            err_r       <= 1'b0;
            idx_r       <= '0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= req_ready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            if (accept_s) begin
                we_r  <= req_we;
                err_r <= req_err_s;
                idx_r <= req_idx_s;
            end
        end
    end

    // Next state and latency counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (LATENCY == 1)) begin
                    state_nxt_s = RESP;
                    cnt_nxt_s   = 4'd0;
                end else if (accept_s) begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Response payload is captured entering RESP, held while in RESP, cleared otherwise.
    always_comb begin
        req_ready_nxt_s = (state_nxt_s == IDLE);
        rsp_valid_nxt_s = (state_nxt_s == RESP);
        rsp_rdata_nxt_s = 32'd0;
        rsp_err_nxt_s   = 1'b0;
        if ((state_nxt_s == RESP) && (state_r != RESP)) begin
            rsp_rdata_nxt_s = rd_load_s ? arr_rdata_s : 32'd0;
            rsp_err_nxt_s   = rd_err_s;
        end else if (state_nxt_s == RESP) begin
            rsp_rdata_nxt_s = rsp_rdata_r;
            rsp_err_nxt_s   = rsp_err_r;
        end else begin
            rsp_rdata_nxt_s = 32'd0;
            rsp_err_nxt_s   = 1'b0;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one LATENCY=2 and one LATENCY=1 instance, directed and random
// transactions checked against a word-array reference model and latency/handshake rules.
module tb_mem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_d [2];
    logic        req_we_d    [2];
    logic        rsp_ready_d [2];
    logic [31:0] req_addr_d  [2];
    logic [31:0] req_wdata_d [2];
    wire  [1:0]  req_ready_w;
    wire  [1:0]  rsp_valid_w;
    wire  [1:0]  rsp_err_w;
    wire  [31:0] rsp_rdata_w [2];

    int          lat_tab [2] = '{2, 1};
    logic [31:0] model_mem [2][DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2), .DEPTH(DEPTH)) u_dut_l2 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_d[0]),
        .req_ready (req_ready_w[0]),
        .req_we    (req_we_d[0]),
        .req_addr  (req_addr_d[0]),
        .req_wdata (req_wdata_d[0]),
        .rsp_valid (rsp_valid_w[0]),
        .rsp_ready (rsp_ready_d[0]),
        .rsp_rdata (rsp_rdata_w[0]),
        .rsp_err   (rsp_err_w[0])
    );

    mem_responder #(.LATENCY(1), .DEPTH(DEPTH)) u_dut_l1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_d[1]),
        .req_ready (req_ready_w[1]),
        .req_we    (req_we_d[1]),
        .req_addr  (req_addr_d[1]),
        .req_wdata (req_wdata_d[1]),
        .rsp_valid (rsp_valid_w[1]),
        .rsp_ready (rsp_ready_d[1]),
        .rsp_rdata (rsp_rdata_w[1]),
        .rsp_err   (rsp_err_w[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err_f(input logic [31:0] addr);
        return ((addr % 32'd4) != 32'd0) || ((addr / 32'd4) >= 32'(DEPTH));
    endfunction

    task automatic check_quiet(input int d, input string tag);
        check({tag, "_valid"}, 32'(rsp_valid_w[d]), 32'd0);
        check({tag, "_rdata"}, rsp_rdata_w[d], 32'd0);
        check({tag, "_err"},   32'(rsp_err_w[d]), 32'd0);
    endtask

    // One transaction; called at a negedge, returns at the negedge after the response is taken.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input string tag);
        int          lat;
        int          t;
        logic        e_err;
        logic [31:0] e_rdata;
        lat     = lat_tab[d];
        e_err   = exp_err_f(addr);
        e_rdata = (!we && !e_err) ? model_mem[d][int'(addr >> 2)] : 32'd0;
        t = 0;
        while (!req_ready_w[d] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready_before"}, 32'(req_ready_w[d]), 32'd1);
        req_valid_d[d] = 1'b1;
        req_we_d[d]    = we;
        req_addr_d[d]  = addr;
        req_wdata_d[d] = wdata;
        rsp_ready_d[d] = (hold == 0);
        @(posedge clk);
        if (we && !e_err) model_mem[d][int'(addr >> 2)] = wdata;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check({tag, "_ready_busy"}, 32'(req_ready_w[d]), 32'd0);
            if (k < lat) begin
                check_quiet(d, {tag, "_wait"});
            end else begin
                check({tag, "_valid"}, 32'(rsp_valid_w[d]), 32'd1);
                check({tag, "_rdata"}, rsp_rdata_w[d], e_rdata);
                check({tag, "_err"},   32'(rsp_err_w[d]), 32'(e_err));
            end
            // Stray store while busy must be ignored.
            req_valid_d[d] = 1'($urandom_range(0, 1));
            req_we_d[d]    = 1'b1;
            req_addr_d[d]  = $urandom_range(0, DEPTH - 1) * 4;
            req_wdata_d[d] = $urandom();
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid_w[d]), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata_w[d], e_rdata);
            check({tag, "_hold_err"},   32'(rsp_err_w[d]), 32'(e_err));
            check({tag, "_hold_ready"}, 32'(req_ready_w[d]), 32'd0);
        end
        rsp_ready_d[d] = 1'b1;
        @(negedge clk);
        req_valid_d[d] = 1'b0;
        check_quiet(d, {tag, "_done"});
        check({tag, "_ready_after"}, 32'(req_ready_w[d]), 32'd1);
    endtask

    // req_valid held high: one acceptance per LATENCY+1 cycles.
    task automatic stream(input int d, input logic [31:0] addr, input string tag);
        int          lat;
        logic        on;
        logic [31:0] e_rdata;
        lat     = lat_tab[d];
        e_rdata = model_mem[d][int'(addr >> 2)];
        check({tag, "_ready_start"}, 32'(req_ready_w[d]), 32'd1);
        req_valid_d[d] = 1'b1;
        req_we_d[d]    = 1'b0;
        req_addr_d[d]  = addr;
        rsp_ready_d[d] = 1'b1;
        for (int k = 1; k <= 4 * (lat + 1); k++) begin
            @(negedge clk);
            on = ((k % (lat + 1)) == lat);
            check({tag, "_valid"}, 32'(rsp_valid_w[d]), 32'(on));
            check({tag, "_ready"}, 32'(req_ready_w[d]), 32'((k % (lat + 1)) == 0));
            check({tag, "_rdata"}, rsp_rdata_w[d], on ? e_rdata : 32'd0);
        end
        req_valid_d[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        int          r;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid_d[d] = 1'b0;
            req_we_d[d]    = 1'b0;
            req_addr_d[d]  = 32'd0;
            req_wdata_d[d] = 32'd0;
            rsp_ready_d[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", 32'(req_ready_w[d]), 32'd0);
            check_quiet(d, "reset");
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("post_reset_ready", 32'(req_ready_w[d]), 32'd1);
        end

        // Fill both arrays so every later load has a defined expectation.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                txn(d, 1'b1, 32'(i * 4), $urandom(), 0, "init");
            end
        end

        txn(0, 1'b1, 32'h64, 32'h7, 0, "st_0x64");
        txn(0, 1'b0, 32'h64, 32'h0, 0, "ld_0x64");
        check("ld_0x64_model", model_mem[0][25], 32'h7);
        txn(0, 1'b1, 32'h0, 32'h1234, 0, "st_0x0");
        txn(0, 1'b0, 32'h62, 32'h0, 0, "ld_misaligned");
        txn(0, 1'b1, 32'h100, 32'hBAD0BAD0, 0, "st_out_of_range");
        txn(0, 1'b0, 32'h100, 32'h0, 0, "ld_out_of_range");
        txn(0, 1'b0, 32'h0, 32'h0, 0, "ld_0x0_intact");
        txn(0, 1'b0, 32'h64, 32'h0, 5, "ld_hold5");
        txn(1, 1'b1, 32'h60, 32'hDEADBEEF, 0, "l1_st_0x60");
        txn(1, 1'b0, 32'h60, 32'h0, 0, "l1_ld_0x60");
        txn(1, 1'b0, 32'h60, 32'h0, 3, "l1_ld_hold3");

        // Reset while the LATENCY=2 instance is in WAIT after a store.
        req_valid_d[0] = 1'b1;
        req_we_d[0]    = 1'b1;
        req_addr_d[0]  = 32'h60;
        req_wdata_d[0] = 32'h5;
        @(posedge clk);
        model_mem[0][24] = 32'h5;
        @(negedge clk);
        req_valid_d[0] = 1'b0;
        check_quiet(0, "rst_wait_pre");
        reset = 1'b1;
        #1;
        check_quiet(0, "rst_wait_in");
        check("rst_wait_in_ready", 32'(req_ready_w[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_wait_ready", 32'(req_ready_w[0]), 32'd1);
            check_quiet(0, "rst_wait_drop");
        end
        txn(0, 1'b0, 32'h60, 32'h0, 0, "rst_ld_0x60");

        stream(0, 32'h64, "stream_l2");
        @(negedge clk);
        stream(1, 32'h60, "stream_l1");
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    addr = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
                end else if (r == 1) begin
                    addr = $urandom_range(DEPTH, 1023) * 4;
                end else if (r == 2) begin
                    addr = $urandom() | 32'h8000_0000;
                end else begin
                    addr = $urandom_range(0, 7) * 4;
                end
                txn(d, 1'($urandom_range(0, 1)), addr, $urandom(),
                    $urandom_range(0, 2), "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
